// File: rtl/mv_result_collector.sv
// rtl/mv_result_collector.sv - FWFT result FIFO with issue credits for the mat-vec pipeline
module mv_result_collector #(
   parameter  int IDW   = 8,
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_fire,
   output logic            issue_ok,
   input  logic            in_valid,
   input  logic [IDW-1:0]  in_vertex_id,
   input  logic [31:0]     in_x,
   input  logic [31:0]     in_y,
   input  logic [31:0]     in_z,
   input  logic [31:0]     in_w,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IDW-1:0]  out_vertex_id,
   output logic [31:0]     ox,
   output logic [31:0]     oy,
   output logic [31:0]     oz,
   output logic [31:0]     ow,
   output logic [CW-1:0]   occupancy,
   output logic [CW-1:0]   credits,
   output logic            ovf_err,
   output logic            cred_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = IDW + 128;

   logic [EW-1:0]  r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_occ;
   logic [CW-1:0]  r_credits;
   logic           r_ovf_err;
   logic           r_cred_err;

   logic           w_pop;
   logic           w_push;
   logic           w_dec;
   logic           w_not_full;
   logic [EW-1:0]  w_head;

   assign w_not_full = (r_occ < CW'(DEPTH));
   assign w_pop      = (r_occ != '0) & out_ready;
   // A pop frees the head slot at this edge, so a full FIFO can still take a write.
   assign w_push     = in_valid & (w_not_full | w_pop);
   assign w_dec      = issue_fire & (r_credits != '0);

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {in_vertex_id, in_x, in_y, in_z, in_w};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_credits  <= CW'(DEPTH);
         r_ovf_err  <= 1'b0;
         r_cred_err <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);

         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + CW'(1);
            2'b01:   r_occ <= r_occ - CW'(1);
            default: r_occ <= r_occ;
         endcase

         case ({w_pop, w_dec})
            2'b10:   r_credits <= r_credits + CW'(1);
            2'b01:   r_credits <= r_credits - CW'(1);
            default: r_credits <= r_credits;
         endcase

         if (in_valid && !w_push)
            r_ovf_err <= 1'b1;
         if (issue_fire && (r_credits == '0))
            r_cred_err <= 1'b1;
      end
   end

   assign w_head        = r_mem[r_rd_ptr];
   assign out_vertex_id = w_head[EW-1:128];
   assign ox            = w_head[127:96];
   assign oy            = w_head[95:64];
   assign oz            = w_head[63:32];
   assign ow            = w_head[31:0];

   assign out_valid = (r_occ != '0);
   assign issue_ok  = (r_credits != '0);
   assign occupancy = r_occ;
   assign credits   = r_credits;
   assign ovf_err   = r_ovf_err;
   assign cred_err  = r_cred_err;

endmodule

// File: tb/tb_mv_result_collector.sv
// tb/tb_mv_result_collector.sv - scoreboard bench for mv_result_collector
module tb_mv_result_collector;

   localparam int IDW = 8;
   localparam int DEPTH = 8;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LAT = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            issue_fire = 1'b0;
   logic            issue_ok;
   logic            in_valid = 1'b0;
   logic [IDW-1:0]  in_vertex_id = '0;
   logic [31:0]     in_x = '0, in_y = '0, in_z = '0, in_w = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [IDW-1:0]  out_vertex_id;
   logic [31:0]     ox, oy, oz, ow;
   logic [CW-1:0]   occupancy;
   logic [CW-1:0]   credits;
   logic            ovf_err;
   logic            cred_err;

   mv_result_collector #(.IDW(IDW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .issue_fire(issue_fire), .issue_ok(issue_ok),
      .in_valid(in_valid), .in_vertex_id(in_vertex_id),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_vertex_id(out_vertex_id),
      .ox(ox), .oy(oy), .oz(oz), .ow(ow),
      .occupancy(occupancy), .credits(credits),
      .ovf_err(ovf_err), .cred_err(cred_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [135:0] d;
   } pend_t;

   logic [135:0] exp_q[$];
   pend_t        pend[$];
   int n_chk = 0;
   int n_pass = 0;
   int m_occ, m_cred, cnt;
   bit m_ovf, m_cerr;
   logic [7:0] next_id;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cnt);
   endtask

   // Monitor: every DUT handshake pops the oldest expected result.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
            end else begin
               logic [135:0] e;
               e = exp_q.pop_front();
               chk("out_vertex_id", 64'(out_vertex_id), 64'(e[135:128]));
               chk("ox", 64'(ox), 64'(e[127:96]));
               chk("oy", 64'(oy), 64'(e[95:64]));
               chk("oz", 64'(oz), 64'(e[63:32]));
               chk("ow", 64'(ow), 64'(e[31:0]));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_state();
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("credits", 64'(credits), 64'(m_cred));
      chk("out_valid", 64'(out_valid), 64'(m_occ != 0));
      chk("issue_ok", 64'(issue_ok), 64'(m_cred != 0));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      chk("cred_err", 64'(cred_err), 64'(m_cerr));
   endtask

   function automatic logic [135:0] mk(input logic [7:0] id);
      return {id, $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One clock with explicit inputs; called at posedge+1.
   task automatic cyc(input bit iss, input bit inv, input logic [135:0] d, input bit rdy);
      bit pop, push, dec;
      issue_fire = iss;
      in_valid   = inv;
      {in_vertex_id, in_x, in_y, in_z, in_w} = d;
      out_ready  = rdy;
      pop  = (m_occ != 0) && rdy;
      push = inv && ((m_occ < DEPTH) || pop);
      dec  = iss && (m_cred != 0);
      if (push) exp_q.push_back(d);
      if (inv && !push) m_ovf = 1;
      if (iss && m_cred == 0) m_cerr = 1;
      m_occ  = m_occ + int'(push) - int'(pop);
      m_cred = m_cred + int'(pop) - int'(dec);
      @(posedge clk);
      #1;
      cnt++;
      check_state();
   endtask

   // One clock with a fixed-latency multiplier feeding in_valid.
   task automatic run(input bit iss, input bit rdy);
      bit inv;
      logic [135:0] d;
      inv = 0;
      d = '0;
      if (pend.size() > 0 && pend[0].due == cnt) begin
         inv = 1;
         d = pend.pop_front().d;
      end
      if (iss) begin
         pend_t p;
         p.due = cnt + LAT;
         p.d = mk(next_id);
         next_id++;
         pend.push_back(p);
      end
      cyc(iss, inv, d, rdy);
   endtask

   task automatic do_reset();
      rst = 1;
      issue_fire = 0;
      in_valid = 0;
      out_ready = 0;
      exp_q.delete();
      pend.delete();
      m_occ = 0; m_cred = DEPTH; m_ovf = 0; m_cerr = 0;
      @(posedge clk);
      #1;
      cnt++;
      rst = 0;
      check_state();
   endtask

   initial begin
      logic [135:0] d;
      cnt = 0;
      next_id = 0;
      @(posedge clk);
      #1;
      do_reset();
      cyc(0, 0, '0, 0);

      // Single result into empty FIFO, popped the cycle it appears.
      d = {8'h2A, 32'h3F800000, $urandom(), $urandom(), $urandom()};
      cyc(1, 1, d, 1);
      cyc(0, 0, '0, 1);
      // Issue and pop in the same cycle keep credits steady.
      cyc(0, 1, mk(8'h2B), 1);
      cyc(1, 0, '0, 1);
      cyc(0, 0, '0, 1);

      // Eight back-to-back issues fill the FIFO with ids 0..7.
      next_id = 0;
      for (int i = 0; i < 8; i++) run(1, 0);
      for (int i = 0; i < LAT; i++) run(0, 0);

      cyc(1, 0, '0, 0);                 // issue with no credit
      cyc(0, 1, mk(8'h55), 0);          // overflow drop
      cyc(0, 1, mk(8'h08), 1);          // full + simultaneous pop/push
      cyc(1, 0, '0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, '0, 1);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      // Mid-stream reset with five entries held.
      do_reset();
      for (int i = 0; i < 5; i++) run(1, 0);
      for (int i = 0; i < LAT; i++) run(0, 0);
      chk("occ_before_rst", 64'(occupancy), 64'd5);
      do_reset();

      // Random clean traffic: issuer obeys credits, downstream stalls randomly.
      for (int i = 0; i < 400; i++)
         run((m_cred > 0) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0);
      for (int i = 0; i < 50 && (pend.size() > 0 || m_occ != 0); i++)
         run(0, 1);
      chk("final_empty", 64'(exp_q.size()), 64'd0);
      chk("final_credits", 64'(credits), 64'(DEPTH));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
